arbitro_pop_ctrl: RTL and testbench

- Pop scheduler for the two virtual-channel FIFOs (VC0, VC1) that feed the D0/D1 demux arbiter.
- Each cycle it chooses at most one VC to pop, based on three inputs: head-word destination, downstream D0/D1 almost-full, and a fairness counter.
- It emits the one-cycle-delayed pop strobes that the demux arbiter uses to steer and push the popped word.
- It sits between the VC FIFOs' status/head outputs and the demux arbiter's pop_delay_VC0/pop_delay_VC1 inputs.

---
 rtl/arbitro_pkg.sv | 20 ++
 rtl/arbitro_pop_ctrl_if.sv | 30 +++
 rtl/arbitro_sel.sv | 41 ++++
 rtl/arbitro_pop_ctrl.sv | 103 ++++++++++
 tb/tb_arbitro_pop_ctrl.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/arbitro_pkg.sv
// rtl/arbitro_pkg.sv - shared encodings and defaults for the VC pop scheduler
package arbitro_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    localparam int DATA_W_DEF     = 6;
    localparam int DEST_BIT_DEF   = 4;
    localparam int MAX_CONSEC_DEF = 4;
    localparam int CNT_W_DEF      = 3;

    // Almost-full flag of the destination FIFO addressed by a head word
    function automatic logic dest_af(input logic dest, input logic d0_af, input logic d1_af);
        return dest ? d1_af : d0_af;
    endfunction

endpackage

// File: rtl/arbitro_pop_ctrl_if.sv
// rtl/arbitro_pop_ctrl_if.sv - VC status/head inputs and pop strobe outputs of the scheduler
interface arbitro_pop_ctrl_if #(
    parameter int DATA_W = arbitro_pkg::DATA_W_DEF
);
    logic [DATA_W-1:0] VC0_head;
    logic [DATA_W-1:0] VC1_head;
    logic              VC0_empty;
    logic              VC1_empty;
    logic              D0_almost_full;
    logic              D1_almost_full;
    logic              pop_VC0;
    logic              pop_VC1;
    logic              pop_delay_VC0;
    logic              pop_delay_VC1;
    logic [1:0]        state;

    // Environment side: FIFO status and demux feedback
    modport master (
        output VC0_head, VC1_head, VC0_empty, VC1_empty,
        output D0_almost_full, D1_almost_full,
        input  pop_VC0, pop_VC1, pop_delay_VC0, pop_delay_VC1, state
    );

    // Scheduler side
    modport slave (
        input  VC0_head, VC1_head, VC0_empty, VC1_empty,
        input  D0_almost_full, D1_almost_full,
        output pop_VC0, pop_VC1, pop_delay_VC0, pop_delay_VC1, state
    );
endinterface

// File: rtl/arbitro_sel.sv
// rtl/arbitro_sel.sv - combinational eligibility and grant priority for VC0/VC1
module arbitro_sel
    import arbitro_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEST_BIT = DEST_BIT_DEF
) (
    input  logic [DATA_W-1:0] VC0_head,
    input  logic [DATA_W-1:0] VC1_head,
    input  logic              VC0_empty,
    input  logic              VC1_empty,
    input  logic              D0_almost_full,
    input  logic              D1_almost_full,
    input  logic              cnt_at_max,
    output logic              pop_VC0,
    output logic              pop_VC1
);

    logic elig_vc0;
    logic elig_vc1;

    // Each VC is judged only against its own destination, so neither head blocks the other
    always_comb begin
        elig_vc0 = !VC0_empty && !dest_af(VC0_head[DEST_BIT], D0_almost_full, D1_almost_full);
        elig_vc1 = !VC1_empty && !dest_af(VC1_head[DEST_BIT], D0_almost_full, D1_almost_full);
    end

    // Fairness override first, then VC0 preference, then VC1 as fallback
    always_comb begin
        pop_VC0 = 1'b0;
        pop_VC1 = 1'b0;
        if (cnt_at_max && elig_vc1) begin
            pop_VC1 = 1'b1;
        end else if (elig_vc0) begin
            pop_VC0 = 1'b1;
        end else if (elig_vc1) begin
            pop_VC1 = 1'b1;
        end
    end

endmodule

// File: rtl/arbitro_pop_ctrl.sv
// rtl/arbitro_pop_ctrl.sv - VC pop scheduler: fairness counter, delayed pop strobes, state
module arbitro_pop_ctrl
    import arbitro_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEST_BIT   = DEST_BIT_DEF,
    parameter int MAX_CONSEC = MAX_CONSEC_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    arbitro_pop_ctrl_if.slave  bus
);

    logic             sel_vc0;
    logic             sel_vc1;
    logic             pop_vc0;
    logic             pop_vc1;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             cnt_at_max;
    state_t           state_q;
    state_t           state_d;

    assign cnt_at_max = (cnt_q == CNT_W'(MAX_CONSEC));

    arbitro_sel #(
        .DATA_W   (DATA_W),
        .DEST_BIT (DEST_BIT)
    ) u_sel (
        .VC0_head       (bus.VC0_head),
        .VC1_head       (bus.VC1_head),
        .VC0_empty      (bus.VC0_empty),
        .VC1_empty      (bus.VC1_empty),
        .D0_almost_full (bus.D0_almost_full),
        .D1_almost_full (bus.D1_almost_full),
        .cnt_at_max     (cnt_at_max),
        .pop_VC0        (sel_vc0),
        .pop_VC1        (sel_vc1)
    );

    // Pops are suppressed for the whole time reset is held, not just at edges
    always_comb begin
        pop_vc0 = sel_vc0 && !reset;
        pop_vc1 = sel_vc1 && !reset;
    end

    // Count consecutive VC0 wins only while VC1 is waiting; saturate at the limit
    always_comb begin
        cnt_d = cnt_q;
        if (bus.VC1_empty || pop_vc1) begin
            cnt_d = '0;
        end else if (pop_vc0 && !cnt_at_max) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Fairness counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // One-cycle delayed pops line up with the FIFO's registered read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.pop_delay_VC0 <= 1'b0;
            bus.pop_delay_VC1 <= 1'b0;
        end else begin
            bus.pop_delay_VC0 <= pop_vc0;
            bus.pop_delay_VC1 <= pop_vc1;
        end
    end

    // Next state follows this cycle's grant and empties directly
    always_comb begin
        state_d = state_q;
        if (pop_vc0 || pop_vc1) begin
            state_d = ST_SERVE;
        end else if (bus.VC0_empty && bus.VC1_empty) begin
            state_d = ST_IDLE;
        end else begin
            state_d = ST_STALL;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.pop_VC0 = pop_vc0;
    assign bus.pop_VC1 = pop_vc1;
    assign bus.state   = state_q;

endmodule

// File: tb/tb_arbitro_pop_ctrl.sv
// tb/tb_arbitro_pop_ctrl.sv - scoreboard bench for the VC pop scheduler
module tb_arbitro_pop_ctrl;
    import arbitro_pkg::*;

    localparam logic [1:0] I = 2'd0;
    localparam logic [1:0] S = 2'd1;
    localparam logic [1:0] T = 2'd2;

    typedef struct {
        logic       p0;
        logic       p1;
        logic       pd0;
        logic       pd1;
        logic [1:0] st;
    } exp_t;

    logic clk;
    logic reset;
    exp_t sb[$];
    int   n_tests;
    int   n_fail;
    logic prev_p0;
    logic prev_p1;
    logic [1:0] prev_st;

    arbitro_pop_ctrl_if #(.DATA_W(6)) bus ();

    arbitro_pop_ctrl #(
        .DATA_W     (6),
        .DEST_BIT   (4),
        .MAX_CONSEC (4),
        .CNT_W      (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // One cycle of stimulus; expected pops and next state are hand-computed per vector
    task automatic step(input logic r, input logic [5:0] h0, input logic [5:0] h1,
                        input logic e0, input logic e1, input logic a0, input logic a1,
                        input logic x0, input logic x1, input logic [1:0] xs);
        exp_t ent;
        @(posedge clk);
        #1;
        reset              = r;
        bus.VC0_head       = h0;
        bus.VC1_head       = h1;
        bus.VC0_empty      = e0;
        bus.VC1_empty      = e1;
        bus.D0_almost_full = a0;
        bus.D1_almost_full = a1;
        if (r) begin
            ent.p0 = 1'b0; ent.p1 = 1'b0; ent.pd0 = 1'b0; ent.pd1 = 1'b0; ent.st = I;
            prev_p0 = 1'b0; prev_p1 = 1'b0; prev_st = I;
        end else begin
            ent.p0 = x0; ent.p1 = x1; ent.pd0 = prev_p0; ent.pd1 = prev_p1; ent.st = prev_st;
            prev_p0 = x0; prev_p1 = x1; prev_st = xs;
        end
        sb.push_back(ent);
    endtask

    // Monitor: compare every presented cycle against the head of the scoreboard
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("pop_VC0", {1'b0, bus.pop_VC0}, {1'b0, e.p0});
            check("pop_VC1", {1'b0, bus.pop_VC1}, {1'b0, e.p1});
            check("pop_delay_VC0", {1'b0, bus.pop_delay_VC0}, {1'b0, e.pd0});
            check("pop_delay_VC1", {1'b0, bus.pop_delay_VC1}, {1'b0, e.pd1});
            check("state", bus.state, e.st);
            check("pop_onehot", {1'b0, bus.pop_VC0 & bus.pop_VC1}, 2'd0);
        end
    end

    initial begin
        n_tests = 0; n_fail = 0;
        prev_p0 = 1'b0; prev_p1 = 1'b0; prev_st = I;
        reset = 1'b1;
        bus.VC0_head = '0; bus.VC1_head = '0;
        bus.VC0_empty = 1'b1; bus.VC1_empty = 1'b1;
        bus.D0_almost_full = 1'b0; bus.D1_almost_full = 1'b0;
        repeat (2) @(posedge clk);

        // VC0 only: heads 0x05, 0x15, 0x03, then drain to idle
        step(0, 6'h05, 6'h00, 0, 1, 0, 0, 1, 0, S);
        step(0, 6'h15, 6'h00, 0, 1, 0, 0, 1, 0, S);
        step(0, 6'h03, 6'h00, 0, 1, 0, 0, 1, 0, S);
        step(0, 6'h00, 6'h00, 1, 1, 0, 0, 0, 0, I);
        step(0, 6'h00, 6'h00, 1, 1, 0, 0, 0, 0, I);

        // Both VCs D0-bound: four VC0 grants then a forced VC1, twice
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) step(0, 6'h01, 6'h02, 0, 0, 0, 0, 1, 0, S);
            step(0, 6'h01, 6'h02, 0, 0, 0, 0, 0, 1, S);
        end

        // Counter reaches 3, VC1 empties (clears), refill must not force VC1
        step(0, 6'h01, 6'h02, 0, 0, 0, 0, 1, 0, S);
        step(0, 6'h01, 6'h02, 0, 0, 0, 0, 1, 0, S);
        step(0, 6'h01, 6'h02, 0, 0, 0, 0, 1, 0, S);
        step(0, 6'h01, 6'h02, 0, 1, 0, 0, 1, 0, S);
        for (int j = 0; j < 4; j++) step(0, 6'h01, 6'h02, 0, 0, 0, 0, 1, 0, S);
        step(0, 6'h01, 6'h02, 0, 0, 0, 0, 0, 1, S);

        // No head-of-line blocking in either direction
        step(0, 6'h10, 6'h02, 0, 0, 0, 1, 0, 1, S);
        step(0, 6'h02, 6'h10, 0, 0, 0, 1, 1, 0, S);

        // Both almost-full: stall with counter held at 1, then release D0
        step(0, 6'h01, 6'h02, 0, 0, 1, 1, 0, 0, T);
        step(0, 6'h01, 6'h02, 0, 0, 0, 1, 1, 0, S);

        // VC0 empties in its would-be pop cycle
        step(0, 6'h01, 6'h02, 1, 0, 0, 0, 0, 1, S);

        // Counter at max but VC1 ineligible: VC0 still served, force waits
        for (int j = 0; j < 4; j++) step(0, 6'h01, 6'h02, 0, 0, 0, 0, 1, 0, S);
        step(0, 6'h01, 6'h12, 0, 0, 0, 1, 1, 0, S);
        step(0, 6'h01, 6'h12, 0, 0, 0, 0, 0, 1, S);

        // Stall with only VC0 present
        step(0, 6'h01, 6'h00, 0, 1, 1, 0, 0, 0, T);

        // Reset mid-burst; inputs still qualify right after release
        step(0, 6'h01, 6'h00, 0, 1, 0, 0, 1, 0, S);
        step(0, 6'h01, 6'h00, 0, 1, 0, 0, 1, 0, S);
        step(1, 6'h01, 6'h00, 0, 1, 0, 0, 0, 0, I);
        step(0, 6'h01, 6'h00, 0, 1, 0, 0, 1, 0, S);

        // Reset while counter is 3 must restart the fairness count
        for (int j = 0; j < 3; j++) step(0, 6'h01, 6'h02, 0, 0, 0, 0, 1, 0, S);
        step(1, 6'h01, 6'h02, 0, 0, 0, 0, 0, 0, I);
        for (int j = 0; j < 4; j++) step(0, 6'h01, 6'h02, 0, 0, 0, 0, 1, 0, S);
        step(0, 6'h01, 6'h02, 0, 0, 0, 0, 0, 1, S);

        step(0, 6'h00, 6'h00, 1, 1, 0, 0, 0, 0, I);
        step(0, 6'h00, 6'h00, 1, 1, 0, 0, 0, 0, I);

        for (int j = 0; j < 10 && sb.size() > 0; j++) @(posedge clk);
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left expected 0", sb.size());
        end
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
